regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard and optional write-to-read bypass, for the pipelined core. It replaces the single-write, two-read register file. It provides NRD combinational read ports and two write ports: ALU writeback on port 0 and load return on port 1. It also tracks which destinations have an outstanding write, so decode can stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2; AW = log2(NREG)
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports; 0 = visible next cycle
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  packed read addresses; port k is bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data
- rd_busy  out  NRD  per-port busy flag of the addressed register
- wr0_en  in  1  write port 0 valid (ALU)
- wr0_addr  in  AW  write port 0 address
- wr0_data  in  XLEN  write port 0 data
- wr1_en  in  1  write port 1 valid (load)
- wr1_addr  in  AW  write port 1 address
- wr1_data  in  XLEN  write port 1 data
- rsv_en  in  1  reserve destination (issue)
- rsv_addr  in  AW  register to mark busy
- busy_cnt  out  AW+1  number of registers currently busy (registered)

## Operation
- Storage: NREG x XLEN array and NREG busy bits. With ZERO_REG=1, entry 0 is not implemented: it reads 0, writes to it are dropped, and it is never busy.
- Write, at rising clk:
  - If wr0_en or wr1_en is set, the addressed entry takes that port's data.
  - If both ports target the same address, port 1 wins.
- Busy clear: a write on either port clears busy[addr].
- Busy set: rsv_en sets busy[rsv_addr].
- Same register written and reserved in one cycle: the set wins and busy stays 1. This models a new producer issuing as the old one retires.
- Read data, combinational:
  - rd_data[k] = array[rd_addr[k]] (0 for address 0 when ZERO_REG=1).
  - With BYPASS=1, a read matching an enabled write address returns that write's data instead, with port 1 taking priority over port 0.
- Read busy, combinational:
  - rd_busy[k] = busy[rd_addr[k]].
  - With BYPASS=1, rd_busy[k] is forced 0 when a same-cycle write matches.
  - A same-cycle reservation is not visible until the next cycle.
- busy_cnt: registered population count of the busy bits, updated every cycle from the next-state busy vector. busy_cnt = NREG is legal.

## Timing
- Reset (rst_n = 0, asynchronous, takes effect mid-cycle):
  - All array entries go to 0 and all busy bits to 0; busy_cnt = 0.
  - rd_data reads 0 and rd_busy reads 0 for any address, while reset is held.
  - Writes and reservations presented during reset are dropped.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0, where the old value is read during the write cycle.
- Reservation-to-busy latency: 1 cycle.
- Write-to-busy-clear latency: 0 cycles with BYPASS=1; 1 cycle otherwise.
- busy_cnt lags the busy vector by 0 cycles: it is computed from next-state and registered alongside it.
- No handshake backpressure: every write and reservation presented is accepted in its cycle.
- Reserving an already-busy register leaves it busy and does not double-count.
- Writing a non-busy register is legal and leaves busy = 0.

## Test plan
- Reset, then read every address on all ports -> rd_data = 0, rd_busy = 0, busy_cnt = 0.
- wr0 writes x5 = 0xDEADBEEF; in the same cycle port 0 reads x5:
  - BYPASS=1 -> 0xDEADBEEF in that cycle.
  - BYPASS=0 -> 0 in that cycle, then 0xDEADBEEF next cycle.
- wr0 (x7 = 0x11) and wr1 (x7 = 0x22) in the same cycle -> next cycle x7 reads 0x22. With BYPASS=1, the same-cycle read of x7 also returns 0x22.
- Writes to x0 = 0xFFFFFFFF and rsv_en on x0 with ZERO_REG=1 -> x0 reads 0, busy stays 0, busy_cnt stays 0.
- Reserve x3, then x4 on consecutive cycles -> busy_cnt goes 1 then 2. Next cycle, write x3 and reserve x3 together -> x3 stays busy, busy_cnt stays 2. Then write x3 and x4 -> busy_cnt = 0.
- Write x9 = 0x1234 and reserve x10, then pulse rst_n low mid-cycle -> x9 reads 0 and rd_busy = 0 before the next clk edge; busy_cnt = 0.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file for the pipelined core. It has NRD
// combinational read ports and two write ports: port 0 carries ALU writeback
// and port 1 carries load return. A per-register busy scoreboard records
// destinations with an outstanding producer, so decode can stall on RAW
// hazards. With BYPASS set, write data and busy-clear are visible on the read
// ports in the same cycle as the write.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   rd_addr   packed read addresses, port k at [k*AW +: AW]
//   rd_data   packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy   busy flag of the register addressed by each read port
//   wr0_*     write port 0 (ALU writeback): enable, address, data
//   wr1_*     write port 1 (load return): enable, address, data; wins ties
//   rsv_*     reserve (mark busy) a destination register at issue
//   busy_cnt  registered count of busy registers (0..NREG)
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] dec_wr0;
  logic [NREG-1:0] dec_wr1;
  logic [NREG-1:0] dec_rsv;
  logic [AW:0]     cnt_next;
  logic            wr0_eff;
  logic            wr1_eff;
  logic            rsv_eff;

  // With ZERO_REG, any write or reservation aimed at register 0 is simply
  // dropped here, so entry 0 never changes from its reset value of zero and
  // never becomes busy.
  assign wr0_eff = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_eff = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
  assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // One-hot decode of each write and reservation target. The next busy
  // vector clears on a write and then sets on a reservation, so a register
  // that is retired and re-issued in the same cycle stays busy.
  always_comb begin
    dec_wr0   = wr0_eff ? (NREG'(1) << wr0_addr) : '0;
    dec_wr1   = wr1_eff ? (NREG'(1) << wr1_addr) : '0;
    dec_rsv   = rsv_eff ? (NREG'(1) << rsv_addr) : '0;
    busy_next = (busy_q & ~(dec_wr0 | dec_wr1)) | dec_rsv;
  end

  // Population count of the next-state busy vector, so the registered count
  // always matches the busy bits it is stored alongside.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  // Storage array. Port 1 is tested first so it wins a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dec_wr1[i]) begin
          mem_q[i] <= wr1_data;
        end else if (dec_wr0[i]) begin
          mem_q[i] <= wr0_data;
        end
      end
    end
  end

  // Busy scoreboard and its registered population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // Read ports. The bypass is gated by rst_n so that writes presented while
  // reset is held cannot leak onto the read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit0;
    logic          hit1;

    assign addr = rd_addr[k*AW +: AW];
    assign hit0 = (BYPASS != 0) && rst_n && wr0_eff && (wr0_addr == addr);
    assign hit1 = (BYPASS != 0) && rst_n && wr1_eff && (wr1_addr == addr);

    assign rd_data[k*XLEN +: XLEN] = hit1 ? wr1_data :
                                     hit0 ? wr0_data : mem_q[addr];
    assign rd_busy[k] = (hit0 || hit1) ? 1'b0 : busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed testbench for regfile_mp. Two instances share every input: dut_b
// with BYPASS=1 and dut_n with BYPASS=0, both with ZERO_REG=1, NREG=32,
// XLEN=32, NRD=2. Inputs change on the falling edge; combinational outputs
// are sampled 1 time unit later and registered outputs after the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b;
  logic [NRD*XLEN-1:0] rd_data_n;
  logic [NRD-1:0]      rd_busy_b;
  logic [NRD-1:0]      rd_busy_n;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [AW:0]         busy_cnt_b;
  logic [AW:0]         busy_cnt_n;

  int checks;
  int failures;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_n)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wr0_en   = 1'b0;
    wr0_addr = '0;
    wr0_data = '0;
    wr1_en   = 1'b0;
    wr1_addr = '0;
    wr1_data = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Reset, then every address on both ports reads zero and not busy.
  task automatic test_reset();
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < NREG; a++) begin
      rd_addr = {5'(NREG - 1 - a), 5'(a)};
      #1;
      checks++;
      if (rd_data_b !== 64'h0) begin
        failures++;
        $display("[TB] FAIL reset_data_b addr=%0d: got %h expected 0", a, rd_data_b);
      end
      checks++;
      if (rd_data_n !== 64'h0) begin
        failures++;
        $display("[TB] FAIL reset_data_n addr=%0d: got %h expected 0", a, rd_data_n);
      end
      checks++;
      if (rd_busy_b !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_busy_b addr=%0d: got %b expected 00", a, rd_busy_b);
      end
      checks++;
      if (rd_busy_n !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_busy_n addr=%0d: got %b expected 00", a, rd_busy_n);
      end
    end
    checks++;
    if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_busy_cnt: got %0d/%0d expected 0", busy_cnt_b, busy_cnt_n);
    end
  endtask

  // x5 written on port 0 while port 0 reads x5.
  task automatic test_bypass();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL bypass_same_cycle_b: got %h expected deadbeef", rd_data_b[31:0]);
    end
    checks++;
    if (rd_data_n[31:0] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL nobypass_same_cycle_n: got %h expected 0", rd_data_n[31:0]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF || rd_data_n[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL write_next_cycle: got %h/%h expected deadbeef", rd_data_b[31:0], rd_data_n[31:0]);
    end
    checks++;
    if (busy_cnt_b !== 6'd0 || rd_busy_b[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_nonbusy: got cnt=%0d busy=%b expected 0/0", busy_cnt_b, rd_busy_b[0]);
    end
  endtask

  // Both write ports hit x7; port 1 must win.
  task automatic test_dual_write();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    rd_addr = {5'd7, 5'd5};
    #1;
    checks++;
    if (rd_data_b[63:32] !== 32'h22) begin
      failures++;
      $display("[TB] FAIL dual_bypass_b: got %h expected 22", rd_data_b[63:32]);
    end
    checks++;
    if (rd_data_n[63:32] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL dual_old_n: got %h expected 0", rd_data_n[63:32]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[63:32] !== 32'h22 || rd_data_n[63:32] !== 32'h22) begin
      failures++;
      $display("[TB] FAIL dual_stored: got %h/%h expected 22", rd_data_b[63:32], rd_data_n[63:32]);
    end
  endtask

  // Writes and a reservation aimed at x0 must all be dropped.
  task automatic test_zero_reg();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b00) begin
      failures++;
      $display("[TB] FAIL zero_same_cycle: got %h busy=%b expected 0/00", rd_data_b, rd_busy_b);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
      failures++;
      $display("[TB] FAIL zero_data: got %h/%h expected 0", rd_data_b, rd_data_n);
    end
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      failures++;
      $display("[TB] FAIL zero_busy: got %b/%b expected 00", rd_busy_b, rd_busy_n);
    end
    checks++;
    if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0) begin
      failures++;
      $display("[TB] FAIL zero_busy_cnt: got %0d/%0d expected 0", busy_cnt_b, busy_cnt_n);
    end
  endtask

  // Reserve x3 and x4, then retire-and-reissue x3, then retire both.
  task automatic test_busy();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    rd_addr = {5'd4, 5'd3};
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rsv_same_cycle: got %b/%b expected 0", rd_busy_b[0], rd_busy_n[0]);
    end
    @(negedge clk);
    rsv_addr = 5'd4;
    #1;
    checks++;
    if (busy_cnt_b !== 6'd1 || busy_cnt_n !== 6'd1) begin
      failures++;
      $display("[TB] FAIL busy_cnt_one: got %0d/%0d expected 1", busy_cnt_b, busy_cnt_n);
    end
    checks++;
    if (rd_busy_b !== 2'b01 || rd_busy_n !== 2'b01) begin
      failures++;
      $display("[TB] FAIL busy_x3_only: got %b/%b expected 01", rd_busy_b, rd_busy_n);
    end
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
    #1;
    checks++;
    if (busy_cnt_b !== 6'd2 || busy_cnt_n !== 6'd2) begin
      failures++;
      $display("[TB] FAIL busy_cnt_two: got %0d/%0d expected 2", busy_cnt_b, busy_cnt_n);
    end
    checks++;
    if (rd_busy_b !== 2'b10) begin
      failures++;
      $display("[TB] FAIL busy_clear_bypass_b: got %b expected 10", rd_busy_b);
    end
    checks++;
    if (rd_busy_n !== 2'b11) begin
      failures++;
      $display("[TB] FAIL busy_no_bypass_n: got %b expected 11", rd_busy_n);
    end
    checks++;
    if (rd_data_b[31:0] !== 32'h33) begin
      failures++;
      $display("[TB] FAIL bypass_x3_b: got %h expected 33", rd_data_b[31:0]);
    end
    @(negedge clk);
    rsv_en = 1'b0;
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h44;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h55;
    #1;
    checks++;
    if (busy_cnt_b !== 6'd2 || busy_cnt_n !== 6'd2) begin
      failures++;
      $display("[TB] FAIL set_wins_cnt: got %0d/%0d expected 2", busy_cnt_b, busy_cnt_n);
    end
    checks++;
    if (rd_busy_n !== 2'b11) begin
      failures++;
      $display("[TB] FAIL set_wins_busy_n: got %b expected 11", rd_busy_n);
    end
    checks++;
    if (rd_busy_b !== 2'b00) begin
      failures++;
      $display("[TB] FAIL two_port_clear_b: got %b expected 00", rd_busy_b);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0) begin
      failures++;
      $display("[TB] FAIL busy_cnt_zero: got %0d/%0d expected 0", busy_cnt_b, busy_cnt_n);
    end
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      failures++;
      $display("[TB] FAIL busy_cleared: got %b/%b expected 00", rd_busy_b, rd_busy_n);
    end
    checks++;
    if (rd_data_n !== {32'h55, 32'h44}) begin
      failures++;
      $display("[TB] FAIL x3_x4_data: got %h expected 0000005500000044", rd_data_n);
    end
  endtask

  // Reserving an already-busy register must not double-count.
  task automatic test_double_reserve();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    rd_addr = {5'd0, 5'd12};
    @(negedge clk);
    #1;
    checks++;
    if (busy_cnt_b !== 6'd1) begin
      failures++;
      $display("[TB] FAIL double_rsv_first: got %0d expected 1", busy_cnt_b);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy_cnt_b !== 6'd1 || busy_cnt_n !== 6'd1 || rd_busy_b[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL double_rsv_count: got %0d/%0d busy=%b expected 1/1/1", busy_cnt_b, busy_cnt_n, rd_busy_b[0]);
    end
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hC0DE;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy_cnt_b !== 6'd0 || rd_busy_n[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL double_rsv_retire: got %0d busy=%b expected 0/0", busy_cnt_b, rd_busy_n[0]);
    end
  endtask

  // Asynchronous reset asserted mid-cycle clears state before the next edge.
  task automatic test_reset_midcycle();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    rd_addr = {5'd10, 5'd9};
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h1234 || rd_busy_n[1] !== 1'b1 || busy_cnt_b !== 6'd1) begin
      failures++;
      $display("[TB] FAIL pre_reset_state: got %h busy=%b cnt=%0d expected 1234/1/1", rd_data_b[31:0], rd_busy_n[1], busy_cnt_b);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_reset_data: got %h/%h expected 0", rd_data_b[31:0], rd_data_n[31:0]);
    end
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      failures++;
      $display("[TB] FAIL async_reset_busy: got %b/%b expected 00", rd_busy_b, rd_busy_n);
    end
    checks++;
    if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_cnt: got %0d/%0d expected 0", busy_cnt_b, busy_cnt_n);
    end
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hAAAA;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_gates_bypass: got %h expected 0", rd_data_b[31:0]);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0 || rd_busy_n[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_drops_writes: got %h/%h busy=%b expected 0/0/0", rd_data_b[31:0], rd_data_n[31:0], rd_busy_n[1]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_busy();
    test_double_reserve();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
